bubble_sort_ctrl: RTL and testbench
===================================

Name: bubble_sort_ctrl

Overview:
- Sequencer that sorts N words in place in the data memory, ascending and unsigned.
- Sits directly upstream of the data memory and is its only master.
- Drives the memory's write address, read address, mode and write data. Consumes its registered read data.
- Started by a one-cycle pulse. Reports busy, done and a swap count.

Parameters:
- N, 10, number of elements to sort; legal range 0..32.
- BASE, 0, memory address of element 0; BASE+N-1 must be <= 31.
- DW, 32, data width.
- AW, 5, memory address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sort when idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sort completes.
- swap_count  out  16  swaps made in the current or last sort.
- mem_wr_addr  out  AW  memory write address (address1).
- mem_rd_addr  out  AW  memory read address (address2).
- mem_mode  out  2  2'b01 = write this cycle; 2'b00 otherwise.
- mem_wr_data  out  DW  memory write data.
- mem_rd_data  in  DW  memory read data; equals mem[mem_rd_addr sampled at the previous rising edge].

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; busy=0, done=0, swap_count=0.
  - mem_mode=0, mem_wr_addr=0, mem_rd_addr=0, mem_wr_data=0.
  - Internal pass index i, element index j, swapped flag and operands a/b are cleared.
  - Reset mid-sort abandons the operation. Memory is left partially sorted; there is no rollback.
- States: IDLE, RDA, RDB, CMP, WRA, WRB, NEXT, FIN.
- IDLE:
  - On start: clear swap_count, i=0, j=0, swapped=0.
  - If N<2, go to FIN; otherwise go to RDA.
- RDA: mem_rd_addr=BASE+j, then go to RDB.
- RDB: mem_rd_addr=BASE+j+1; latch a=mem_rd_data (element j), then go to CMP.
- CMP: latch b=mem_rd_data (element j+1).
  - If a > b (unsigned), go to WRA.
  - Otherwise go to NEXT. Equal values are never swapped, so the sort is stable.
- WRA: mem_mode=01, mem_wr_addr=BASE+j, mem_wr_data=b, then go to WRB.
- WRB: mem_mode=01, mem_wr_addr=BASE+j+1, mem_wr_data=a.
  - swap_count+=1, saturating at 16'hFFFF.
  - swapped=1, then go to NEXT.
- NEXT:
  - If j+1 < N-1-i: j+=1, go to RDA.
  - Else, at end of pass:
    - If swapped==0 or i==N-2, go to FIN.
    - Else i+=1, j=0, swapped=0, go to RDA.
- FIN: done=1 for exactly this cycle, busy=0, then go to IDLE.
- busy:
  - High in RDA..NEXT; low in IDLE and FIN.
  - start while not in IDLE is ignored.
- Write discipline:
  - mem_mode is 01 only in WRA and WRB.
  - Address and data are stable for the whole write cycle.
  - No read result is consumed in a cycle that follows a write to the same address.
- Timing:
  - A compare without swap costs 4 cycles; with swap, 6.
  - Latency from start to done = 1 + sum of per-compare costs + 1 (FIN).
- Outputs are registered; no combinational path from start or mem_rd_data to any output.
- swap_count holds its value after FIN until the next accepted start.

Test Plan:
- Reset: assert rst low mid-idle and mid-sort (in WRA) -> all outputs 0 immediately, state IDLE. A following start runs a full sort correctly.
- Sorted input 1..10, N=10 -> exactly one pass (9 compares, 36 cycles) with no mem_mode=01 cycle. done 38 cycles after start; swap_count=0.
- Mixed set 78,456,1,89,13,56,267,102,3,51 -> memory becomes 1,3,13,51,56,78,89,102,267,456; swap_count=25; exactly 50 write cycles.
- Reverse input 10..1 -> ascending 1..10; swap_count=45; 9 passes, with no early exit.
- Duplicates 5,5,2,5 with N=4 -> result 2,5,5,5; swap_count=2. The check must confirm equal values are never written.
- Edges:
  - N=1 -> done 2 cycles after start, no memory access.
  - start pulsed while busy -> ignored, result unchanged.
  - Memory values near 32'hFFFFFFFF vs 0 -> compared unsigned, so 0 sorts first.

Source files
------------

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl
//   Sorts N words of the attached data memory in place, ascending and
//   unsigned, starting at address BASE. The controller is the memory's only
//   master: it drives both address ports, the write mode and the write data,
//   and consumes the memory's registered read data (one-cycle read latency).
//
//   Ports
//     clk          rising-edge clock
//     rst          asynchronous, active-low reset
//     start        one-cycle pulse; accepted only while idle
//     busy         high while a sort is in progress
//     done         one-cycle pulse when the sort completes
//     swap_count   swaps made in the current or last sort (saturating)
//     mem_wr_addr  memory write address (address1)
//     mem_rd_addr  memory read address (address2)
//     mem_mode     2'b01 = write this cycle, 2'b00 otherwise
//     mem_wr_data  memory write data
//     mem_rd_data  memory read data, mem[mem_rd_addr at previous edge]
module bubble_sort_ctrl #(
  parameter int N    = 10,
  parameter int BASE = 0,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [15:0]   swap_count,
  output logic [AW-1:0] mem_wr_addr,
  output logic [AW-1:0] mem_rd_addr,
  output logic [1:0]    mem_mode,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    RDA,
    RDB,
    CMP,
    WRA,
    WRB,
    NEXT,
    FIN
  } state_t;

  state_t        state;
  logic [5:0]    i;        // pass index
  logic [5:0]    j;        // element index within the pass
  logic          swapped;  // any swap in the current pass
  logic [DW-1:0] a;        // element j

  logic more_in_pass;
  logic last_pass;

  function automatic logic [AW-1:0] addr_of(input int idx);
    return AW'(BASE + idx);
  endfunction

  always_comb begin
    more_in_pass = (int'(j) + 1) < (N - 1 - int'(i));
    last_pass    = (int'(i) == N - 2);
  end

  // All outputs are registered, so each transition loads the values the
  // next state presents to the memory. Operand b is never held separately:
  // it is captured straight into mem_wr_data on the CMP->WRA transition,
  // which is the only place it is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      swap_count  <= '0;
      mem_mode    <= 2'b00;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_wr_data <= '0;
      i           <= '0;
      j           <= '0;
      swapped     <= 1'b0;
      a           <= '0;
    end else begin
      done     <= 1'b0;
      mem_mode <= 2'b00;
      unique case (state)
        IDLE: begin
          if (start) begin
            swap_count <= '0;
            i          <= '0;
            j          <= '0;
            swapped    <= 1'b0;
            if (N < 2) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= RDA;
              busy        <= 1'b1;
              mem_rd_addr <= addr_of(0);
            end
          end
        end
        RDA: begin
          state       <= RDB;
          mem_rd_addr <= addr_of(int'(j) + 1);
        end
        RDB: begin
          a     <= mem_rd_data;
          state <= CMP;
        end
        CMP: begin
          // Strict compare: equal neighbours stay put, keeping the sort stable.
          if (a > mem_rd_data) begin
            state       <= WRA;
            mem_mode    <= 2'b01;
            mem_wr_addr <= addr_of(int'(j));
            mem_wr_data <= mem_rd_data;
          end else begin
            state <= NEXT;
          end
        end
        WRA: begin
          state       <= WRB;
          mem_mode    <= 2'b01;
          mem_wr_addr <= addr_of(int'(j) + 1);
          mem_wr_data <= a;
        end
        WRB: begin
          if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
          swapped <= 1'b1;
          state   <= NEXT;
        end
        NEXT: begin
          if (more_in_pass) begin
            j           <= j + 6'd1;
            mem_rd_addr <= addr_of(int'(j) + 1);
            state       <= RDA;
          end else if (!swapped || last_pass) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i           <= i + 6'd1;
            j           <= '0;
            swapped     <= 1'b0;
            mem_rd_addr <= addr_of(0);
            state       <= RDA;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// tb_bubble_sort_ctrl
//   Three controller instances (N=10/BASE=0, N=4/BASE=3, N=1/BASE=7), each
//   with its own 32-word memory model that has one-cycle registered reads.
module tb_bubble_sort_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N0 = 10;
  localparam int B0 = 0;
  localparam int N1 = 4;
  localparam int B1 = 3;
  localparam int N2 = 1;
  localparam int B2 = 7;
  localparam int TIMEOUT = 2000;

  typedef struct {
    int swaps;
    int lat;
    int writes;
  } meta_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] busy, done;
  logic [2:0][15:0]   swc;
  logic [2:0][AW-1:0] wa, ra;
  logic [2:0][1:0]    mode;
  logic [2:0][DW-1:0] wd, rd;

  logic [DW-1:0] mem [3][32];
  int wr_cnt [3];
  int same_cnt [3];
  int bad_cnt [3];
  logic cnt_clr = 1'b0;
  logic ld_en = 1'b0;
  int ld_k = 0;
  int ld_addr = 0;
  logic [DW-1:0] ld_data = '0;

  int tests = 0;
  int fails = 0;
  int last_lat = 0;
  logic [DW-1:0] exp_words [$];
  meta_t exp_meta [$];

  always #5 clk = ~clk;

  bubble_sort_ctrl #(.N(N0), .BASE(B0), .DW(DW), .AW(AW)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .swap_count(swc[0]), .mem_wr_addr(wa[0]), .mem_rd_addr(ra[0]),
    .mem_mode(mode[0]), .mem_wr_data(wd[0]), .mem_rd_data(rd[0]));

  bubble_sort_ctrl #(.N(N1), .BASE(B1), .DW(DW), .AW(AW)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .swap_count(swc[1]), .mem_wr_addr(wa[1]), .mem_rd_addr(ra[1]),
    .mem_mode(mode[1]), .mem_wr_data(wd[1]), .mem_rd_data(rd[1]));

  bubble_sort_ctrl #(.N(N2), .BASE(B2), .DW(DW), .AW(AW)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .swap_count(swc[2]), .mem_wr_addr(wa[2]), .mem_rd_addr(ra[2]),
    .mem_mode(mode[2]), .mem_wr_data(wd[2]), .mem_rd_data(rd[2]));

  function automatic int nof(input int k);
    case (k)
      0: return N0;
      1: return N1;
      default: return N2;
    endcase
  endfunction

  function automatic int bof(input int k);
    case (k)
      0: return B0;
      1: return B1;
      default: return B2;
    endcase
  endfunction

  // Memory models plus write monitors: total writes, writes that would not
  // change the stored value, and writes outside the sort window.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rd[k] <= mem[k][ra[k]];
      if (cnt_clr) begin
        wr_cnt[k]   <= 0;
        same_cnt[k] <= 0;
        bad_cnt[k]  <= 0;
      end else if (mode[k] == 2'b01) begin
        wr_cnt[k] <= wr_cnt[k] + 1;
        if (mem[k][wa[k]] == wd[k]) same_cnt[k] <= same_cnt[k] + 1;
        if (int'(wa[k]) < bof(k) || int'(wa[k]) > bof(k) + nof(k) - 1)
          bad_cnt[k] <= bad_cnt[k] + 1;
      end else if (mode[k] !== 2'b00) begin
        bad_cnt[k] <= bad_cnt[k] + 1;
      end
      if (mode[k] == 2'b01) mem[k][wa[k]] <= wd[k];
      if (ld_en && ld_k == k) mem[k][ld_addr] <= ld_data;
    end
  end

  task automatic load(input int k, input int addr, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_k    = k;
    ld_addr = addr;
    ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Reference sort of the window, expectations queued, then the DUT run and
  // its results popped and compared. poke re-pulses start mid-sort.
  task automatic run_sort(input int k, input string name, input bit poke);
    int n, b, sw, lat, cyc, busy_bad;
    logic [DW-1:0] m [$];
    logic [DW-1:0] t, got, expw;
    bit swapped, timed_out;
    meta_t e;
    n = nof(k);
    b = bof(k);
    for (int x = 0; x < n; x++) m.push_back(mem[k][b + x]);
    sw  = 0;
    lat = 2;
    for (int p = 0; p < n - 1; p++) begin
      swapped = 1'b0;
      for (int q = 0; q < n - 1 - p; q++) begin
        if (m[q] > m[q + 1]) begin
          t = m[q]; m[q] = m[q + 1]; m[q + 1] = t;
          sw++;
          swapped = 1'b1;
          lat += 6;
        end else begin
          lat += 4;
        end
      end
      if (!swapped) break;
    end
    foreach (m[x]) exp_words.push_back(m[x]);
    e.swaps  = sw;
    e.lat    = lat;
    e.writes = 2 * sw;
    exp_meta.push_back(e);

    start[k] = 1'b1;
    cnt_clr  = 1'b1;
    @(posedge clk); #1;
    start[k]  = 1'b0;
    cnt_clr   = 1'b0;
    cyc       = 2;
    busy_bad  = 0;
    timed_out = 1'b0;
    while (done[k] !== 1'b1) begin
      if (busy[k] !== 1'b1) busy_bad++;
      if (cyc >= TIMEOUT) begin
        timed_out = 1'b1;
        break;
      end
      if (poke && cyc == 10) start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      cyc++;
    end
    last_lat = cyc;

    e = exp_meta.pop_front();
    tests++;
    if (timed_out) begin
      fails++;
      $display("FAIL %s_done: no done within %0d cycles", name, TIMEOUT);
    end else if (cyc != e.lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc, e.lat);
    end
    tests++;
    if (busy[k] !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_at_done: got %b, expected 0", name, busy[k]);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL %s_busy_during: %0d cycles low, expected 0", name, busy_bad);
    end
    tests++;
    if (swc[k] !== 16'(e.swaps)) begin
      fails++;
      $display("FAIL %s_swap_count: got %0d, expected %0d", name, swc[k], e.swaps);
    end
    tests++;
    if (wr_cnt[k] != e.writes) begin
      fails++;
      $display("FAIL %s_writes: got %0d, expected %0d", name, wr_cnt[k], e.writes);
    end
    tests++;
    if (same_cnt[k] != 0 || bad_cnt[k] != 0) begin
      fails++;
      $display("FAIL %s_write_discipline: %0d equal-value, %0d bad writes, expected 0/0",
               name, same_cnt[k], bad_cnt[k]);
    end
    for (int x = 0; x < n; x++) begin
      expw = exp_words.pop_front();
      got  = mem[k][b + x];
      tests++;
      if (got !== expw) begin
        fails++;
        $display("FAIL %s_word%0d: got %0d, expected %0d", name, x, got, expw);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (done[k] !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: done still %b one cycle later, expected 0", name, done[k]);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    tests++;
    if (busy !== 3'b000 || done !== 3'b000) begin
      fails++;
      $display("FAIL %s_flags: busy=%b done=%b, expected 000/000", name, busy, done);
    end
    tests++;
    if (swc[0] !== 16'd0 || mode[0] !== 2'b00) begin
      fails++;
      $display("FAIL %s_count_mode: swap_count=%0d mode=%b, expected 0/00", name, swc[0], mode[0]);
    end
    tests++;
    if (wa[0] !== '0 || ra[0] !== '0 || wd[0] !== '0) begin
      fails++;
      $display("FAIL %s_bus: wr_addr=%0d rd_addr=%0d wr_data=%0d, expected 0/0/0",
               name, wa[0], ra[0], wd[0]);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1 check_zero_outputs("reset");
    #20 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sorted();
    for (int x = 0; x < 10; x++) load(0, B0 + x, DW'(x + 1));
    run_sort(0, "sorted", 1'b0);
    tests++;
    if (last_lat != 38 || swc[0] !== 16'd0 || wr_cnt[0] != 0) begin
      fails++;
      $display("FAIL sorted_fixed: lat=%0d swaps=%0d writes=%0d, expected 38/0/0",
               last_lat, swc[0], wr_cnt[0]);
    end
  endtask

  task automatic test_mixed();
    logic [DW-1:0] v [10] = '{78, 456, 1, 89, 13, 56, 267, 102, 3, 51};
    logic [DW-1:0] s [10] = '{1, 3, 13, 51, 56, 78, 89, 102, 267, 456};
    for (int x = 0; x < 10; x++) load(0, B0 + x, v[x]);
    run_sort(0, "mixed", 1'b0);
    tests++;
    if (swc[0] !== 16'd25 || wr_cnt[0] != 50) begin
      fails++;
      $display("FAIL mixed_fixed: swaps=%0d writes=%0d, expected 25/50", swc[0], wr_cnt[0]);
    end
    for (int x = 0; x < 10; x++) begin
      tests++;
      if (mem[0][B0 + x] !== s[x]) begin
        fails++;
        $display("FAIL mixed_const%0d: got %0d, expected %0d", x, mem[0][B0 + x], s[x]);
      end
    end
  endtask

  task automatic test_reset_idle();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (swc[0] !== 16'd25) begin
      fails++;
      $display("FAIL hold_swap_count: got %0d, expected 25", swc[0]);
    end
    #3 rst = 1'b0;
    #1 check_zero_outputs("reset_idle");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reverse_with_reset();
    int guard;
    for (int x = 0; x < 10; x++) load(0, B0 + x, DW'(10 - x));
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    guard = 0;
    while (mode[0] !== 2'b01 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    tests++;
    if (guard >= 200) begin
      fails++;
      $display("FAIL midsort_write_seen: no write cycle within 200 cycles, expected one");
    end
    #3 rst = 1'b0;
    #1 check_zero_outputs("reset_midsort");
    @(posedge clk); #1;
    rst = 1'b1;
    tests++;
    if (mem[0][B0] !== 32'd10 || mem[0][B0 + 1] !== 32'd9) begin
      fails++;
      $display("FAIL midsort_no_write: got %0d,%0d, expected 10,9", mem[0][B0], mem[0][B0 + 1]);
    end
    @(posedge clk); #1;
    run_sort(0, "after_reset", 1'b0);
    for (int x = 0; x < 10; x++) load(0, B0 + x, DW'(10 - x));
    run_sort(0, "reverse", 1'b0);
    tests++;
    if (swc[0] !== 16'd45 || last_lat != 272) begin
      fails++;
      $display("FAIL reverse_fixed: swaps=%0d lat=%0d, expected 45/272", swc[0], last_lat);
    end
  endtask

  task automatic test_duplicates();
    logic [DW-1:0] v [4] = '{5, 5, 2, 5};
    load(1, B1 - 1, 32'd99);
    load(1, B1 + 4, 32'd0);
    for (int x = 0; x < 4; x++) load(1, B1 + x, v[x]);
    run_sort(1, "dups", 1'b0);
    tests++;
    if (swc[1] !== 16'd2 || same_cnt[1] != 0) begin
      fails++;
      $display("FAIL dups_fixed: swaps=%0d equal_writes=%0d, expected 2/0", swc[1], same_cnt[1]);
    end
    tests++;
    if (mem[1][B1] !== 32'd2 || mem[1][B1 - 1] !== 32'd99 || mem[1][B1 + 4] !== 32'd0) begin
      fails++;
      $display("FAIL dups_window: got first=%0d below=%0d above=%0d, expected 2/99/0",
               mem[1][B1], mem[1][B1 - 1], mem[1][B1 + 4]);
    end
  endtask

  task automatic test_n1();
    load(2, B2, 32'd42);
    run_sort(2, "n1", 1'b0);
    tests++;
    if (last_lat != 2 || ra[2] !== '0 || wa[2] !== '0 || wr_cnt[2] != 0 || mem[2][B2] !== 32'd42) begin
      fails++;
      $display("FAIL n1_fixed: lat=%0d rd_addr=%0d wr_addr=%0d writes=%0d word=%0d, expected 2/0/0/0/42",
               last_lat, ra[2], wa[2], wr_cnt[2], mem[2][B2]);
    end
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] v [10] = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 32'h1, 32'h80000000,
                              32'h7FFFFFFF, 32'h5, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFFF};
    for (int x = 0; x < 10; x++) load(0, B0 + x, v[x]);
    run_sort(0, "unsigned", 1'b0);
    tests++;
    if (mem[0][B0] !== 32'h0 || mem[0][B0 + 9] !== 32'hFFFFFFFF || mem[0][B0 + 4] !== 32'h7FFFFFFF) begin
      fails++;
      $display("FAIL unsigned_order: got first=%h mid=%h last=%h, expected 0/7fffffff/ffffffff",
               mem[0][B0], mem[0][B0 + 4], mem[0][B0 + 9]);
    end
  endtask

  task automatic test_start_while_busy();
    for (int x = 0; x < 10; x++) load(0, B0 + x, DW'($urandom_range(0, 999)));
    run_sort(0, "busy_poke", 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int x = 0; x < 10; x++) load(0, B0 + x, DW'($urandom_range(0, 50)));
    run_sort(0, "b2b_first", 1'b0);
    run_sort(0, "b2b_second", 1'b0);
    tests++;
    if (last_lat != 38 || swc[0] !== 16'd0) begin
      fails++;
      $display("FAIL b2b_resort: lat=%0d swaps=%0d, expected 38/0", last_lat, swc[0]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sorted();
    test_mixed();
    test_reset_idle();
    test_reverse_with_reset();
    test_duplicates();
    test_n1();
    test_unsigned();
    test_start_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
